// File: rtl/lite_read_seq.sv
// AXI-Lite read sequencer: each accepted start reads NUM_REGS registers in order.
// Defining LITE_RD_POLL_EN adds DMA-idle status polling after a clean sweep.
module lite_read_seq #(
    parameter int                ADDR_W      = 10,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 4,
    parameter int                BASE_ADDR   = 0,
    parameter int                ADDR_STRIDE = 4,
    parameter logic [DATA_W-1:0] IDLE_MASK   = DATA_W'(1),
    parameter int                POLL_GAP    = 16,
    parameter int                POLL_MAX    = 64,
    localparam int               IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] m_axi_lite_araddr,
    output logic              m_axi_lite_arvalid,
    input  logic              m_axi_lite_arready,
    input  logic [DATA_W-1:0] m_axi_lite_rdata,
    input  logic [1:0]        m_axi_lite_rresp,
    input  logic              m_axi_lite_rvalid,
    output logic              m_axi_lite_rready,
    output logic [DATA_W-1:0] rd_data,
    output logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_resp,
    output logic              dma_idle
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_DATA      = 3'd2,
        S_NEXT      = 3'd3,
        S_DONE      = 3'd4
`ifdef LITE_RD_POLL_EN
        ,
        S_POLL_WAIT = 3'd5,
        S_POLL_ADDR = 3'd6
`endif
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic              rready_q;
    logic              ar_hs;
    logic              r_hs;
    logic              beat_err;
    logic              last_idx;
    logic [ADDR_W-1:0] addr_calc;

    // Valid/ready: a beat transfers on the rising edge where valid and ready are both high;
    // arvalid/araddr are held until that edge, rready is raised one cycle into DATA.
    assign ar_hs     = m_axi_lite_arvalid & m_axi_lite_arready;
    assign r_hs      = m_axi_lite_rvalid & rready_q;
    assign beat_err  = (m_axi_lite_rresp != 2'b00);
    assign last_idx  = (idx == IDX_W'(NUM_REGS - 1));
    assign addr_calc = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE);

    assign m_axi_lite_rready = rready_q;
    assign m_axi_lite_araddr = m_axi_lite_arvalid ? addr_calc : '0;

`ifdef LITE_RD_POLL_EN
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam int TRY_W = $clog2(POLL_MAX + 1);

    logic             polling;
    logic             dma_idle_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [TRY_W-1:0] try_cnt;
    logic             poll_hit;
    logic             poll_last;
    logic             gap_done;

    assign poll_hit  = ((m_axi_lite_rdata & IDLE_MASK) == IDLE_MASK);
    assign poll_last = (try_cnt == TRY_W'(POLL_MAX - 1));
    assign gap_done  = (gap_cnt == GAP_W'(POLL_GAP - 1));
    assign dma_idle  = dma_idle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            polling    <= 1'b0;
            dma_idle_q <= 1'b0;
            gap_cnt    <= '0;
            try_cnt    <= '0;
        end else begin
            gap_cnt <= (state == S_POLL_WAIT) ? gap_cnt + 1'b1 : '0;
            if (state == S_IDLE && start) begin
                dma_idle_q <= 1'b0;
            end else if (r_hs && polling && !beat_err && poll_hit) begin
                dma_idle_q <= 1'b1;
            end
            // DONE is visited once after the sweep and once after the poll loop.
            if (state == S_DONE) begin
                polling <= !err && !polling;
                try_cnt <= '0;
            end else if (r_hs && polling && !beat_err && !poll_hit) begin
                try_cnt <= try_cnt + 1'b1;
            end
        end
    end
`else
    localparam bit CFG_OK = (NUM_REGS >= 1) && (NUM_REGS <= 256) && (POLL_GAP >= 1)
                            && (POLL_MAX >= 1) && (|IDLE_MASK);

    assign dma_idle = ~busy & CFG_OK;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        m_axi_lite_arvalid = 1'b0;
        busy               = (state != S_IDLE);
        done               = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                m_axi_lite_arvalid = 1'b1;
                if (ar_hs) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (r_hs) begin
                    if (beat_err) begin
                        state_nxt = S_DONE;
`ifdef LITE_RD_POLL_EN
                    end else if (polling) begin
                        state_nxt = (poll_hit || poll_last) ? S_DONE : S_POLL_WAIT;
`endif
                    end else begin
                        state_nxt = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                state_nxt = last_idx ? S_DONE : S_ADDR;
            end
            S_DONE: begin
                done = 1'b1;
`ifdef LITE_RD_POLL_EN
                state_nxt = (!err && !polling) ? S_POLL_WAIT : S_IDLE;
`else
                state_nxt = S_IDLE;
`endif
            end
`ifdef LITE_RD_POLL_EN
            S_POLL_WAIT: begin
                if (gap_done) state_nxt = S_POLL_ADDR;
            end
            S_POLL_ADDR: begin
                m_axi_lite_arvalid = 1'b1;
                if (ar_hs) state_nxt = S_DATA;
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            rready_q <= 1'b0;
            rd_data  <= '0;
            rd_idx   <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            err_resp <= 2'b00;
        end else begin
            rready_q <= (state == S_DATA) && !r_hs;
            rd_valid <= r_hs;
            if (r_hs) begin
                rd_data <= m_axi_lite_rdata;
                rd_idx  <= idx;
            end
            // idx returns to 0 in DONE so the poll reads target register 0.
            if (state == S_IDLE && start) begin
                idx <= '0;
            end else if (state == S_NEXT && !last_idx) begin
                idx <= idx + 1'b1;
            end else if (state == S_DONE) begin
                idx <= '0;
            end
            if (state == S_IDLE && start) begin
                err      <= 1'b0;
                err_resp <= 2'b00;
            end else if (r_hs && beat_err) begin
                err <= 1'b1;
                if (!err) err_resp <= m_axi_lite_rresp;
`ifdef LITE_RD_POLL_EN
            end else if (r_hs && polling && !poll_hit && poll_last) begin
                err <= 1'b1;
                if (!err) err_resp <= 2'b11;
`endif
            end
        end
    end

endmodule

// File: tb/tb_lite_read_seq.sv
// Bench for lite_read_seq: negedge-driven AXI-Lite slave, scoreboard of expected beats.
// Poll scenarios run instead of the sweep scenarios when LITE_RD_POLL_EN is defined.
`timescale 1ns/1ps
module tb_lite_read_seq;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 4;
    localparam int IDX_W     = 2;
    localparam int RW        = IDX_W + DATA_W;
    localparam int POLL_GAP  = 16;
`ifdef LITE_RD_POLL_EN
    localparam int POLL_MAX  = 3;
    localparam bit POLL_EN   = 1'b1;
`else
    localparam int POLL_MAX  = 64;
    localparam bit POLL_EN   = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready = 1'b0;
    logic [DATA_W-1:0] rdata = '0;
    logic [1:0]        rresp = 2'b00;
    logic              rvalid = 1'b0;
    logic              rready;
    logic [DATA_W-1:0] rd_data;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_resp;
    logic              dma_idle;

    lite_read_seq #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BASE_ADDR(0),
        .ADDR_STRIDE(4), .IDLE_MASK(32'h1), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid),
        .m_axi_lite_arready(arready), .m_axi_lite_rdata(rdata),
        .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
        .m_axi_lite_rready(rready), .rd_data(rd_data), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
        .err_resp(err_resp), .dma_idle(dma_idle)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int checks = 0;
    int failures = 0;
    logic [RW-1:0]     exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] status_q[$];
    int                ar_rel_q[$];
    logic [ADDR_W-1:0] addr_tbl [NUM_REGS] = '{10'h000, 10'h004, 10'h008, 10'h00C};

    int t_start = 0;
    int rel;
    int done_cnt, done_rel, rdv_cnt, first_rdv_rel, ar_cnt, ar_unstable;
    int stall = 0;
    int err_beat = -1;
    int beat_no = 0;
    bit rand_data = 1'b0;
    bit sweep_over = 1'b0;
    logic              ar_wait = 1'b0;
    logic [ADDR_W-1:0] held_addr;
    logic              pend = 1'b0;
    logic [DATA_W-1:0] pend_data;
    logic [1:0]        pend_resp;
    logic [IDX_W-1:0]  idx_v;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // slave + monitor, everything evaluated away from the rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            pend    = 1'b0;
            ar_wait = 1'b0;
            arready = 1'b0;
            rvalid  = 1'b0;
            rresp   = 2'b00;
            rdata   = '0;
        end else begin
            rel = cyc - t_start;
            if (done) begin
                done_cnt++;
                done_rel   = rel;
                sweep_over = 1'b1;
            end
            if (rd_valid) begin
                rdv_cnt++;
                if (rdv_cnt == 1) first_rdv_rel = rel;
                if (exp_q.size() == 0) check("rd_extra", 1, 0);
                else check("rd_beat", {rd_idx, rd_data}, exp_q.pop_front());
            end
            if (ar_wait && (arvalid !== 1'b1 || araddr !== held_addr)) ar_unstable++;
            rvalid = pend;
            rdata  = pend_data;
            rresp  = pend_resp;
            if (pend && rready) pend = 1'b0;
            ar_wait = 1'b0;
            arready = 1'b0;
            if (arvalid) begin
                if (stall > 0) begin
                    stall--;
                    ar_wait   = 1'b1;
                    held_addr = araddr;
                end else begin
                    arready = 1'b1;
                    ar_cnt++;
                    ar_rel_q.push_back(rel);
                    if (sweep_over) begin
                        check("poll_araddr", araddr, 0);
                        pend_data = (status_q.size() != 0) ? status_q.pop_front() : '0;
                        idx_v     = '0;
                    end else begin
                        if (exp_addr_q.size() == 0) check("ar_extra", 1, 0);
                        else check("araddr", araddr, exp_addr_q.pop_front());
                        pend_data = rand_data ? DATA_W'($urandom) : DATA_W'(araddr);
                        idx_v     = IDX_W'(beat_no);
                    end
                    pend_resp = (beat_no == err_beat) ? 2'b10 : 2'b00;
                    pend      = 1'b1;
                    exp_q.push_back({idx_v, pend_data});
                    beat_no++;
                end
            end
        end
    end

    // driver tasks
    task automatic clear_sb();
        exp_q.delete();
        exp_addr_q.delete();
        ar_rel_q.delete();
        done_cnt = 0; done_rel = -1; rdv_cnt = 0; first_rdv_rel = -1;
        ar_cnt = 0; ar_unstable = 0; beat_no = 0; sweep_over = 1'b0;
    endtask

    task automatic kick(input bit rnd, input int stall_cycles, input int bad_beat);
        clear_sb();
        rand_data = rnd;
        stall     = stall_cycles;
        err_beat  = bad_beat;
        for (int i = 0; i < NUM_REGS; i++) exp_addr_q.push_back(addr_tbl[i]);
        @(negedge clk);
        start   = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_araddr"}, araddr, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_idx"}, rd_idx, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_err_resp"}, err_resp, 0);
        check({tag, "_dma_idle"}, dma_idle, POLL_EN ? 0 : 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifndef LITE_RD_POLL_EN
        // zero-wait sweep, rdata = address
        kick(1'b0, 0, -1);
        check("sweep_busy", busy, 1);
        wait_done(1, 100);
        check("sweep_ar_cnt", ar_cnt, 4);
        check("sweep_first_ar", ar_rel_q.size() > 0 ? ar_rel_q[0] : -1, 1);
        check("sweep_first_rdv", first_rdv_rel, 4);
        check("sweep_done_cycle", done_rel, 17);
        check("sweep_rdv_cnt", rdv_cnt, 4);
        check("sweep_err", err, 0);
        check("sweep_dma_idle", dma_idle, 1);

        // arready held low for 5 cycles on the first read, random data
        kick(1'b1, 5, -1);
        wait_done(1, 100);
        check("stall_stable", ar_unstable, 0);
        check("stall_first_hs", ar_rel_q.size() > 0 ? ar_rel_q[0] : -1, 6);
        check("stall_done_cycle", done_rel, 22);
        check("stall_rdv_cnt", rdv_cnt, 4);

        // SLVERR on the second beat aborts the sweep
        kick(1'b1, 0, 1);
        wait_done(1, 100);
        check("err_flag", err, 1);
        check("err_resp", err_resp, 2'b10);
        check("err_ar_cnt", ar_cnt, 2);
        check("err_rdv_cnt", rdv_cnt, 2);
        check("err_done_cycle", done_rel, 8);
        repeat (10) @(negedge clk);
        check("err_single_done", done_cnt, 1);
        check("err_idle", busy, 0);

        // a fresh start clears the sticky error
        kick(1'b0, 0, -1);
        check("err_cleared", err, 0);
        check("err_resp_cleared", err_resp, 0);
        wait_done(1, 100);
        check("clean_rdv_cnt", rdv_cnt, 4);

        // start while busy is ignored; reset mid-DATA abandons the read
        kick(1'b1, 0, -1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_ar_cnt", ar_cnt, 2);
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        @(negedge clk);
        clear_sb();
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_ar", ar_cnt, 0);
        check("post_rst_busy", busy, 0);
`else
        // status reads 0,0,1: three poll reads, idle after the third
        status_q.delete();
        status_q.push_back(32'h0);
        status_q.push_back(32'h0);
        status_q.push_back(32'h1);
        kick(1'b0, 0, -1);
        wait_done(2, 400);
        check("poll_ar_cnt", ar_cnt, 7);
        check("poll_first", ar_rel_q.size() > 4 ? ar_rel_q[4] : -1, 34);
        check("poll_gap1", ar_rel_q.size() > 5 ? ar_rel_q[5] - ar_rel_q[4] : -1, POLL_GAP + 3);
        check("poll_gap2", ar_rel_q.size() > 6 ? ar_rel_q[6] - ar_rel_q[5] : -1, POLL_GAP + 3);
        check("poll_done_cycle", done_rel, 75);
        check("poll_dma_idle", dma_idle, 1);
        check("poll_err", err, 0);
        check("poll_rdv_cnt", rdv_cnt, 7);
        check("poll_busy", busy, 0);

        // status never idle: timeout after POLL_MAX attempts
        status_q.delete();
        kick(1'b0, 0, -1);
        check("to_dma_cleared", dma_idle, 0);
        wait_done(2, 400);
        check("to_err", err, 1);
        check("to_err_resp", err_resp, 2'b11);
        check("to_dma_idle", dma_idle, 0);
        check("to_ar_cnt", ar_cnt, 7);
        check("to_done_cycle", done_rel, 75);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
